// File: rtl/score_display.sv
// Score readout: converts the 8-bit score to BCD with a double-dabble FSM and
// renders three font glyphs below the maze. Optional: SCORE_LEADING_ZERO_BLANK_EN.
module score_display #(
   parameter int SCORE_X    = 16,
   parameter int SCORE_Y    = 400,
   parameter int SCALE_LOG2 = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] score_in,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic [3:0] bcd_hundreds,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       bcd_valid,
   output logic       conv_done,
   output logic       is_score_pixel,
   output logic       in_score_box
);

   localparam int DIG_W   = 8 << SCALE_LOG2;
   localparam int DIG_H   = 16 << SCALE_LOG2;
   localparam int FIELD_W = 3 * DIG_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state;
   logic [7:0]  conv_src;
   logic [19:0] sr;
   logic [2:0]  cnt;

   // One double-dabble step: bias each BCD nibble >= 5 by 3, then shift left.
   function automatic logic [19:0] dabble_step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

   // Font rows 2..13 packed MSB-first; rows 0,1,14,15 and non-digit codes are blank.
   function automatic logic [7:0] font_row(input logic [3:0] d, input logic [3:0] r);
      logic [95:0] g;
      logic [95:0] sh;
      case (d)
         4'd0:    g = 96'h7C44444C545464444444447C;
         4'd1:    g = 96'h10301010101010101010107C;
         4'd2:    g = 96'h7C040404047C40404040407C;
         4'd3:    g = 96'h7C040404043C04040404047C;
         4'd4:    g = 96'h44444444447C040404040404;
         4'd5:    g = 96'h7C404040407C04040404047C;
         4'd6:    g = 96'h7C404040407C44444444447C;
         4'd7:    g = 96'h7C0404080810102020202020;
         4'd8:    g = 96'h7C444444447C44444444447C;
         4'd9:    g = 96'h7C444444447C04040404047C;
         default: g = '0;
      endcase
      sh = g << {r - 4'd2, 3'b000};
      if (r >= 4'd2 && r <= 4'd13)
         return sh[95:88];
      else
         return 8'h00;
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= LOAD;
         conv_src     <= 8'd0;
         bcd_hundreds <= 4'd0;
         bcd_tens     <= 4'd0;
         bcd_ones     <= 4'd0;
         bcd_valid    <= 1'b0;
         conv_done    <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            IDLE: begin
               if (score_in != conv_src)
                  state <= LOAD;
            end
            LOAD: begin
               conv_src <= score_in;
               sr       <= {12'b0, score_in};
               cnt      <= 3'd0;
               state    <= SHIFT;
            end
            SHIFT: begin
               sr  <= dabble_step(sr);
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7)
                  state <= DONE;
            end
            DONE: begin
               bcd_hundreds <= sr[19:16];
               bcd_tens     <= sr[15:12];
               bcd_ones     <= sr[11:8];
               bcd_valid    <= 1'b1;
               conv_done    <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pixel stage p0: field hit test and glyph lookup from the latched digits.
   logic [10:0] px_p0, py_p0, dx_p0, dy_p0;
   logic        in_box_p0;
   logic [1:0]  digit_p0;
   logic [2:0]  col_p0;
   logic [3:0]  row_p0;
   logic [3:0]  digit_val_p0;
   logic        blank_p0;
   logic [7:0]  font_bits_p0;
   logic        lit_p0;

   assign px_p0     = {1'b0, DrawX};
   assign py_p0     = {1'b0, DrawY};
   assign dx_p0     = px_p0 - 11'(SCORE_X);
   assign dy_p0     = py_p0 - 11'(SCORE_Y);
   assign in_box_p0 = (px_p0 >= 11'(SCORE_X)) && (dx_p0 < 11'(FIELD_W)) &&
                      (py_p0 >= 11'(SCORE_Y)) && (dy_p0 < 11'(DIG_H));
   assign digit_p0  = 2'(dx_p0 >> (3 + SCALE_LOG2));
   assign col_p0    = 3'(dx_p0 >> SCALE_LOG2);
   assign row_p0    = 4'(dy_p0 >> SCALE_LOG2);

   always_comb begin
      digit_val_p0 = bcd_ones;
      blank_p0     = 1'b0;
      case (digit_p0)
         2'd0: begin
            digit_val_p0 = bcd_hundreds;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            blank_p0 = (bcd_hundreds == 4'd0);
`endif
         end
         2'd1: begin
            digit_val_p0 = bcd_tens;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            blank_p0 = (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0);
`endif
         end
         default: digit_val_p0 = bcd_ones;
      endcase
   end

   assign font_bits_p0 = font_row(digit_val_p0, row_p0);
   assign lit_p0       = in_box_p0 && !blank_p0 && font_bits_p0[3'd7 - col_p0];

   // Pixel stage p1: registered mask, aligned with is_food.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         is_score_pixel <= 1'b0;
         in_score_box   <= 1'b0;
      end else begin
         is_score_pixel <= lit_p0;
         in_score_box   <= in_box_p0;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: conversion latency and digits via a
// scoreboard queue, field geometry, glyph pixels and leading-zero handling.
module tb_score_display;

   localparam int SX = 16;
   localparam int SY = 400;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] score_in;
   logic [9:0] DrawX, DrawY;
   logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
   logic       bcd_valid, conv_done, is_score_pixel, in_score_box;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [11:0] exp_q[$];

   score_display #(.SCORE_X(SX), .SCORE_Y(SY), .SCALE_LOG2(1)) dut (
      .Clk(Clk), .Reset(Reset), .score_in(score_in), .DrawX(DrawX), .DrawY(DrawY),
      .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
      .bcd_valid(bcd_valid), .conv_done(conv_done),
      .is_score_pixel(is_score_pixel), .in_score_box(in_score_box)
   );

   always #10 Clk = ~Clk;

   always @(negedge Clk) if (conv_done === 1'b1) done_cnt++;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Advances until conv_done is seen (or the limit expires); reports edges taken
   // and whether the digits stayed unchanged before the pulse.
   task automatic wait_done(input int limit, output int n, output bit held);
      logic [11:0] start;
      start = {bcd_hundreds, bcd_tens, bcd_ones};
      held = 1'b1;
      n = 0;
      while (n < limit) begin
         tick();
         n++;
         if (conv_done === 1'b1) return;
         if ({bcd_hundreds, bcd_tens, bcd_ones} !== start) held = 1'b0;
      end
      n = limit + 1;
   endtask

   task automatic test_reset();
      int n; bit held; int d0;
      logic [11:0] e;
      Reset = 1'b1; score_in = 8'd0; DrawX = 10'd0; DrawY = 10'd0;
      repeat (3) tick();
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h000) begin
         errors++; $display("FAIL reset_digits: got %h want 000", {bcd_hundreds, bcd_tens, bcd_ones});
      end
      checks++;
      if ({bcd_valid, conv_done, is_score_pixel, in_score_box} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {bcd_valid, conv_done, is_score_pixel, in_score_box});
      end
      exp_q.delete();
      exp_q.push_back(to_bcd(0));
      Reset = 1'b0;
      wait_done(30, n, held);
      checks++;
      if (n !== 10) begin
         errors++; $display("FAIL reset_first_latency: got %0d edges want 10", n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL reset_first_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
      checks++;
      if (bcd_valid !== 1'b1) begin
         errors++; $display("FAIL reset_valid: got %b want 1", bcd_valid);
      end
      tick();
      d0 = done_cnt;
      repeat (15) tick();
      checks++;
      if (done_cnt !== d0) begin
         errors++; $display("FAIL idle_no_reconv: got %0d extra pulses want 0", done_cnt - d0);
      end
   endtask

   task automatic test_conv_137();
      int n; bit held;
      logic [11:0] e;
      score_in = 8'd137;
      exp_q.push_back(to_bcd(137));
      wait_done(30, n, held);
      checks++;
      if (n !== 11) begin
         errors++; $display("FAIL conv137_latency: got %0d edges want 11", n);
      end
      checks++;
      if (held !== 1'b1) begin
         errors++; $display("FAIL conv137_hold: got partial update, want digits held at 000");
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL conv137_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
      tick();
      checks++;
      if (conv_done !== 1'b0) begin
         errors++; $display("FAIL conv137_pulse_width: got %b want 0", conv_done);
      end
   endtask

   task automatic test_values();
      int n; bit held;
      logic [11:0] e;
      int vals[3] = '{255, 9, 100};
      foreach (vals[i]) begin
         score_in = 8'(vals[i]);
         exp_q.push_back(to_bcd(vals[i]));
         wait_done(30, n, held);
         checks++;
         if (n !== 11) begin
            errors++; $display("FAIL value_%0d_latency: got %0d edges want 11", vals[i], n);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
         checks++;
         if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
            errors++; $display("FAIL value_%0d_digits: got %h want %h", vals[i], {bcd_hundreds, bcd_tens, bcd_ones}, e);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int n; bit held;
      logic [11:0] e;
      score_in = 8'd50;
      exp_q.push_back(to_bcd(50));
      repeat (3) tick();
      score_in = 8'd51;
      exp_q.push_back(to_bcd(51));
      wait_done(30, n, held);
      checks++;
      if (n !== 8) begin
         errors++; $display("FAIL b2b_first_latency: got %0d edges want 8", n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL b2b_first_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
      wait_done(30, n, held);
      checks++;
      if (n !== 11) begin
         errors++; $display("FAIL b2b_second_latency: got %0d edges want 11", n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL b2b_second_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
   endtask

   task automatic test_reset_abort();
      int n; bit held;
      logic [11:0] e;
      tick();
      score_in = 8'd200;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones, bcd_valid, conv_done} !== 14'd0) begin
         errors++; $display("FAIL abort_reset_state: got %h/%b/%b want 000/0/0",
                            {bcd_hundreds, bcd_tens, bcd_ones}, bcd_valid, conv_done);
      end
      exp_q.delete();
      exp_q.push_back(to_bcd(200));
      Reset = 1'b0;
      wait_done(30, n, held);
      checks++;
      if (n !== 10) begin
         errors++; $display("FAIL abort_reconv_latency: got %0d edges want 10", n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL abort_reconv_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
   endtask

   task automatic test_pixels();
      int n; bit held;
      logic [11:0] e;
      // {DrawX, DrawY, expected pixel, expected box}
      int px[6] = '{SX + 18, SX,      SX + 48, SX - 1,  SX + 18, SX + 18};
      int py[6] = '{SY + 4,  SY + 10, SY + 4,  SY + 4,  SY + 32, SY - 1};
      bit ep[6] = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0};
      bit eb[6] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
      tick();
      score_in = 8'd80;
      exp_q.push_back(to_bcd(80));
      wait_done(30, n, held);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL pix_score_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
      foreach (px[i]) begin
         DrawX = 10'(px[i]);
         DrawY = 10'(py[i]);
         tick();
         checks++;
         if ({is_score_pixel, in_score_box} !== {ep[i], eb[i]}) begin
            errors++; $display("FAIL pix_%0d (x=%0d y=%0d): got pix=%b box=%b want pix=%b box=%b",
                               i, px[i], py[i], is_score_pixel, in_score_box, ep[i], eb[i]);
         end
      end
   endtask

   task automatic test_blank();
      int n; bit held;
      logic [11:0] e;
      int lit[3] = '{0, 0, 0};
      int miss = 0;
      logic [7:0] hrow = 8'h00;
      score_in = 8'd5;
      exp_q.push_back(to_bcd(5));
      wait_done(30, n, held);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if ({bcd_hundreds, bcd_tens, bcd_ones} !== e) begin
         errors++; $display("FAIL blank_score_digits: got %h want %h", {bcd_hundreds, bcd_tens, bcd_ones}, e);
      end
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 48; x++) begin
            DrawX = 10'(SX + x);
            DrawY = 10'(SY + y);
            tick();
            if (in_score_box !== 1'b1) miss++;
            if (is_score_pixel === 1'b1) lit[x / 16]++;
            if (y == 4 && x < 16 && (x % 2) == 0) hrow[7 - x / 2] = is_score_pixel;
         end
      end
      DrawX = 10'd0;
      DrawY = 10'd0;
      checks++;
      if (miss !== 0) begin
         errors++; $display("FAIL scan_box: got %0d pixels outside box want 0", miss);
      end
      checks++;
      if (!(lit[2] > 0)) begin
         errors++; $display("FAIL scan_ones_lit: got %0d lit pixels want >0", lit[2]);
      end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      checks++;
      if (lit[0] !== 0 || lit[1] !== 0) begin
         errors++; $display("FAIL scan_blank: got hundreds=%0d tens=%0d lit want 0/0", lit[0], lit[1]);
      end
      checks++;
      if (hrow !== 8'h00) begin
         errors++; $display("FAIL scan_hundreds_row2: got %h want 00", hrow);
      end
`else
      checks++;
      if (!(lit[0] > 0) || !(lit[1] > 0)) begin
         errors++; $display("FAIL scan_zeros_shown: got hundreds=%0d tens=%0d lit want >0", lit[0], lit[1]);
      end
      checks++;
      if (hrow !== 8'h7C) begin
         errors++; $display("FAIL scan_hundreds_row2: got %h want 7c", hrow);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_conv_137();
      test_values();
      test_back_to_back();
      test_reset_abort();
      test_pixels();
      test_blank();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
